// File: rtl/param_fetch_unit.sv
// param_fetch_unit: block-based instruction prefetch queue.
// Fetches BLOCK_INSNS-wide blocks from the cache one request at a time,
// buffers up to QUEUE_DEPTH blocks and streams single instructions out
// with their word-address PC. Jump/branch redirects flush the queue.
// Optional feature macro: FETCH_BYPASS_EN (empty-queue response bypass).
module param_fetch_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BLOCK_INSNS   = 4,
    parameter int unsigned QUEUE_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]          redirect_address,
    output logic                              cache_req,
    output logic [ADDRESS_WIDTH-1:0]          cache_addr,
    input  logic                              cache_rsp_valid,
    input  logic [BLOCK_INSNS*DATA_WIDTH-1:0] cache_rsp_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             instruction,
    output logic [ADDRESS_WIDTH-1:0]          PC_out,
    output logic                              empty,
    output logic                              full
);
    localparam int unsigned OW = $clog2(BLOCK_INSNS);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned BW = BLOCK_INSNS * DATA_WIDTH;
    localparam logic [CW-1:0]            COUNT_MAX   = CW'(QUEUE_DEPTH);
    localparam logic [OW-1:0]            OFFSET_LAST = OW'(BLOCK_INSNS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BLOCK_STEP  = ADDRESS_WIDTH'(BLOCK_INSNS);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

    state_t                   state, state_next;
    logic [BW-1:0]            blocks [QUEUE_DEPTH];
    logic [CW-1:0]            count, count_next;
    logic [PW-1:0]            rp, rp_next;
    logic [PW-1:0]            wp, wp_next;
    logic [OW-1:0]            offset, offset_next;
    logic [ADDRESS_WIDTH-1:0] pc, pc_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_next;

    logic                     rsp_accept;
    logic                     bypass;
    logic                     pop;
    logic                     offset_wrap;
    logic                     retire;
    logic                     write_en;
    logic [BW-1:0]            head_block;
    logic [DATA_WIDTH-1:0]    head_words [BLOCK_INSNS];

    // Datapath decode, outputs and next-state for FSM, pointers and PCs.
    always_comb begin
        empty       = (count == '0);
        full        = (count == COUNT_MAX);
        rsp_accept  = (state == ST_WAIT) && cache_rsp_valid && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass      = rsp_accept && empty;
`else
        bypass      = 1'b0;
`endif
        head_block  = bypass ? cache_rsp_data : blocks[rp];
        for (int unsigned i = 0; i < BLOCK_INSNS; i++) begin
            head_words[i] = head_block[i*DATA_WIDTH +: DATA_WIDTH];
        end
        instruction = head_words[offset];
        out_valid   = (!empty || bypass) && !redirect_valid;
        pop         = out_valid && out_ready;
        offset_wrap = (offset == OFFSET_LAST);
        retire      = pop && offset_wrap && !bypass;
        // A bypassed block fully consumed in its arrival cycle is never stored.
        write_en    = rsp_accept && !(bypass && pop && offset_wrap);
        cache_req   = reset && (state == ST_REQ) && (count != COUNT_MAX) && !redirect_valid;
        cache_addr  = fetch_pc;
        PC_out      = pc;

        state_next    = state;
        count_next    = count;
        rp_next       = rp;
        wp_next       = wp;
        offset_next   = offset;
        pc_next       = pc;
        fetch_pc_next = fetch_pc;

        if (redirect_valid) begin
            count_next    = '0;
            rp_next       = wp;
            pc_next       = redirect_address;
            offset_next   = redirect_address[OW-1:0];
            fetch_pc_next = {redirect_address[ADDRESS_WIDTH-1:OW], {OW{1'b0}}};
            // Any request still in flight (WAIT or DROP) must have its response discarded.
            if ((state == ST_WAIT || state == ST_DROP) && !cache_rsp_valid) begin
                state_next = ST_DROP;
            end else begin
                state_next = ST_REQ;
            end
        end else begin
            if (pop) begin
                pc_next     = pc + ADDRESS_WIDTH'(1);
                offset_next = offset + OW'(1);
            end
            if (retire) begin
                rp_next = rp + PW'(1);
            end
            if (write_en) begin
                wp_next = wp + PW'(1);
            end
            count_next = count + CW'(write_en) - CW'(retire);
            case (state)
                ST_REQ: begin
                    if (cache_req) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cache_rsp_valid) begin
                        state_next    = ST_REQ;
                        fetch_pc_next = fetch_pc + BLOCK_STEP;
                    end
                end
                ST_DROP: begin
                    if (cache_rsp_valid) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

    // Control state, pointers and program counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_REQ;
            count    <= '0;
            rp       <= '0;
            wp       <= '0;
            offset   <= '0;
            pc       <= '0;
            fetch_pc <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            rp       <= rp_next;
            wp       <= wp_next;
            offset   <= offset_next;
            pc       <= pc_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Block storage; contents are only meaningful between wp and rp.
    always_ff @(posedge clk) begin
        if (write_en) begin
            blocks[wp] <= cache_rsp_data;
        end
    end
endmodule

// File: tb/tb_param_fetch_unit.sv
// Self-checking bench for param_fetch_unit: directed sequences, a redirect
// vector table and a randomized run against a stream-level reference model.
module tb_param_fetch_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BI = 4;
    localparam int unsigned QD = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [AW-1:0]    redirect_address = '0;
    logic             cache_req;
    logic [AW-1:0]    cache_addr;
    logic             cache_rsp_valid = 1'b0;
    logic [BI*DW-1:0] cache_rsp_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    instruction;
    logic [AW-1:0]    PC_out;
    logic             empty;
    logic             full;

    param_fetch_unit #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_INSNS(BI), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_address(redirect_address),
        .cache_req(cache_req), .cache_addr(cache_addr),
        .cache_rsp_valid(cache_rsp_valid), .cache_rsp_data(cache_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .PC_out(PC_out),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: each word address holds a distinct value.
    function automatic logic [DW-1:0] insn_of(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [BI*DW-1:0] block_of(input logic [AW-1:0] a);
        logic [BI*DW-1:0] b;
        b = '0;
        for (int i = 0; i < BI; i++) b[i*DW +: DW] = insn_of(a + AW'(i));
        return b;
    endfunction

    // Reference model state
    int unsigned   rsp_delay = 2;   // 0 selects a random delay of 1..4 per request
    bit            pend = 0;
    bit            pend_stale = 0;
    logic [AW-1:0] pend_addr = '0;
    int unsigned   pend_due = 0;
    logic [AW-1:0] exp_fetch = '0;
    logic [AW-1:0] exp_pc = '0;
    logic [AW-1:0] req_log [$];
    int unsigned   req_count = 0;
    int unsigned   pop_count = 0;

    // Cache model plus fetch-address model: blocks are fetched consecutively
    // from the aligned redirect target; a response is lost if any redirect
    // occurs between its request and its arrival (inclusive).
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 0;
                exp_fetch = '0;
            end else begin
                if (cache_rsp_valid) begin
                    if (!(pend_stale || redirect_valid)) exp_fetch = exp_fetch + AW'(BI);
                    pend = 0;
                end
                if (redirect_valid) begin
                    exp_fetch  = redirect_address & ~AW'(BI - 1);
                    pend_stale = 1;
                end
                if (cache_req) begin
                    check("one_outstanding", pend, 0);
                    check("cache_addr", cache_addr, exp_fetch);
                    req_log.push_back(cache_addr);
                    req_count++;
                    pend       = 1;
                    pend_stale = 0;
                    pend_addr  = cache_addr;
                    pend_due   = cyc + ((rsp_delay == 0) ? $urandom_range(4, 1) : rsp_delay);
                end
            end
            @(posedge clk);
            #1;
            cache_rsp_valid = 1'b0;
            if (reset && pend && cyc == pend_due) begin
                cache_rsp_valid = 1'b1;
                cache_rsp_data  = block_of(pend_addr);
            end
        end
    end

    // Output stream model: consumed instructions run consecutively from the
    // last redirect target (or 0 after reset), wrapping at 2^AW.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_pc = '0;
            end else begin
                if (out_valid && out_ready) begin
                    check("pop_pc", PC_out, exp_pc);
                    check("pop_insn", instruction, insn_of(exp_pc));
                    exp_pc = exp_pc + AW'(1);
                    pop_count++;
                end
                if (redirect_valid) exp_pc = redirect_address;
                if (full) check("full_blocks_req", cache_req, 0);
`ifndef FETCH_BYPASS_EN
                check("valid_vs_empty", out_valid, !empty && !redirect_valid);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        req_log.delete();
        req_count = 0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where cache_req is high.
    task automatic wait_req(input string name);
        int unsigned n;
        n = 0;
        while (!cache_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, cache_req, 1);
    endtask

    task automatic wait_valid(input string name);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, 1);
    endtask

    typedef struct {
        logic [AW-1:0] target;
        int unsigned   delay;
        int unsigned   at_cycle;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_insn;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned gaps;

        vecs[0] = '{32'h0000002E, 3, 1, 32'h0000002C, 32'h0000002E, insn_of(32'h0000002E)};
        vecs[1] = '{32'h0000002E, 1, 1, 32'h0000002C, 32'h0000002E, insn_of(32'h0000002E)};
        vecs[2] = '{32'hFFFFFFFF, 2, 5, 32'hFFFFFFFC, 32'hFFFFFFFF, insn_of(32'hFFFFFFFF)};
        vecs[3] = '{32'h00000013, 4, 7, 32'h00000010, 32'h00000013, insn_of(32'h00000013)};
        vecs[4] = '{32'h00000007, 2, 0, 32'h00000004, 32'h00000007, insn_of(32'h00000007)};

        // Reset values while reset is held low
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_cache_req", cache_req, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_pc", PC_out, 0);
        check("rst_cache_addr", cache_addr, 0);

        // Streaming from 0, cache answering 2 cycles after each request
        rsp_delay = 2;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("first_req", cache_req, 1);
        @(negedge clk);
        @(negedge clk);
        check("first_rsp", cache_rsp_valid, 1);
`ifdef FETCH_BYPASS_EN
        check("bypass_valid", out_valid, 1);
        check("bypass_insn", instruction, insn_of(0));
`else
        check("no_bypass_valid", out_valid, 0);
`endif
        @(negedge clk);
        check("valid_after_rsp", out_valid, 1);
        gaps = 0;
        for (int i = 0; i < 40; i++) begin
            if (!out_valid) gaps++;
            @(negedge clk);
        end
        check("no_gaps", gaps, 0);
        check("req_log_ge3", req_log.size() >= 3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < req_log.size()) check("stream_cache_addr", req_log[i], AW'(i * BI));
        end

        // Consumer stalled: queue fills and requests stop until a block retires
        do_reset();
        repeat (30) @(negedge clk);
        check("fill_req_count", req_count, QD);
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        check("fill_cache_req", cache_req, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            out_ready = 1'b1;
            @(negedge clk);
            check("partial_pop_no_req", cache_req, 0);
        end
        step();
        @(negedge clk);
        check("retire_cycle_no_req", cache_req, 0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("req_after_retire", cache_req, 1);
        repeat (10) @(negedge clk);
        check("refill_req_count", req_count, QD + 1);
        check("refill_full", full, 1);

        // Redirect vector table
        for (int v = 0; v < 5; v++) begin
            rsp_delay = vecs[v].delay;
            do_reset();
            out_ready = 1'b1;
            for (int c = 0; c < vecs[v].at_cycle; c++) step();
            redirect_valid   = 1'b1;
            redirect_address = vecs[v].target;
            @(negedge clk);
            check("redir_out_valid", out_valid, 0);
            check("redir_cache_req", cache_req, 0);
            step();
            redirect_valid   = 1'b0;
            redirect_address = $urandom;
            @(negedge clk);
            check("redir_empty", empty, 1);
            wait_req("redir_req_seen");
            check("redir_cache_addr", cache_addr, vecs[v].exp_addr);
            wait_valid("redir_valid_seen");
            check("redir_first_pc", PC_out, vecs[v].exp_pc);
            check("redir_first_insn", instruction, vecs[v].exp_insn);
            repeat (12) @(negedge clk);
        end

        // Reset pulse mid-stream
        rsp_delay = 2;
        do_reset();
        out_ready = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        #1;
        check("pulse_out_valid", out_valid, 0);
        check("pulse_cache_req", cache_req, 0);
        check("pulse_full", full, 0);
        check("pulse_empty", empty, 1);
        check("pulse_pc", PC_out, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        wait_req("pulse_req_seen");
        check("pulse_restart_addr", cache_addr, 0);
        repeat (20) @(negedge clk);
        check("pulse_resume_pc", exp_pc != 0, 1);

        // Randomized traffic
        rsp_delay = 0;
        do_reset();
        pop_count = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            out_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(24, 0) == 0) begin
                redirect_valid   = 1'b1;
                redirect_address = $urandom_range(1, 0) ? AW'($urandom)
                                                        : (32'hFFFFFFF0 + AW'($urandom_range(15, 0)));
            end else begin
                redirect_valid = 1'b0;
            end
        end
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("random_progress", pop_count > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
